// File: rtl/xps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
//   PS2_TX_BASE      : bus address of the transmitter register
//   STATUS_*_BIT     : bit positions in the status word returned on a read
//   TMO_W / EDGE_W   : widths of the timeout and falling-edge counters
//   state_e          : transmitter FSM state encoding
//   odd_parity()     : PS/2 frame parity bit for a data byte
package xps2_tx_pkg;

  localparam logic [15:0] PS2_TX_BASE     = 16'h0040;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_ERR_BIT  = 1;

  localparam int unsigned TMO_W  = 20;  // covers 15 ms at 50 MHz
  localparam int unsigned EDGE_W = 4;   // counts up to 11 falling edges

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_BITS       = 3'd4,
    ST_ACK        = 3'd5,
    ST_WAIT_IDLE  = 3'd6,
    ST_ERROR      = 3'd7
  } state_e;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/xps2_line_filter.sv
// Conditions one raw PS/2 pad input.
//   clk, rst  : system clock, synchronous active-high reset
//   line_in   : raw pad value (asynchronous to clk)
//   filt_o    : synchronised value, changes only after FILTER_LEN stable cycles
//   fall_o    : one-cycle strobe coincident with filt_o going 1 -> 0
module xps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;
  logic             fall_q;

  // The idle PS/2 bus is high, so the synchroniser and filter start at 1
  // and no false falling edge is reported when reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_in};
      fall_q <= 1'b0;
      // Any return to the current filtered value restarts the stability count,
      // so pulses shorter than FILTER_LEN cycles never reach filt_o.
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        cnt_q  <= '0;
        filt_q <= sync_q[1];
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/xps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device.
//   clk, rst              : system clock, synchronous active-high reset
//   sel, we, data_in      : bus write of the command byte (accepted in IDLE only)
//   ps2_clk_in/_data_in   : raw pad values of PS2_CLK / PS2_DATA
//   ps2_clk_oe/_data_oe   : 1 = pull the open-drain line low
//   busy                  : frame in progress
//   done                  : one-cycle pulse on an acknowledged frame
//   err                   : sticky timeout / missing-ACK flag, cleared by the next write
//   rx_rst                : holds the PS/2 receiver in reset while we own the bus
module xps2_tx
  import xps2_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       we,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_rst
);

  logic clk_filt, clk_fall, data_filt, unused_data_fall;

  xps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .line_in(ps2_clk_in), .filt_o(clk_filt), .fall_o(clk_fall)
  );

  // Only the receiver needs edges on the data line.
  xps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .line_in(ps2_data_in), .filt_o(data_filt), .fall_o(unused_data_fall)
  );

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [8:0]        sh_q, sh_d;      // {parity, data}, bit0 is the next bit out
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, rx_rst_q, rx_rst_d;
  logic go_error, frame_tmo;

  assign frame_tmo = (tmo_q == TMO_W'(FRAME_TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    state_d   = state_q;
    tmo_d     = tmo_q;
    edge_d    = edge_q;
    sh_d      = sh_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rx_rst_d  = rx_rst_q;
    go_error  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel && we) begin
          sh_d     = {odd_parity(data_in), data_in};
          err_d    = 1'b0;
          busy_d   = 1'b1;
          rx_rst_d = 1'b1;
          clk_oe_d = 1'b1;
          tmo_d    = '0;
          edge_d   = '0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmo_q == TMO_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;   // start bit
          state_d   = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (clk_fall) begin
          data_oe_d = ~sh_q[0];
          sh_d      = {1'b0, sh_q[8:1]};
          edge_d    = EDGE_W'(1);
          tmo_d     = '0;
          state_d   = ST_BITS;
        end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          go_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_BITS: begin
        if (frame_tmo) begin
          go_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (clk_fall) begin
            edge_d = edge_q + EDGE_W'(1);
            // Edges 2..9 shift out data bits 1..7 then parity; edge 10 is the stop bit.
            if (edge_q == EDGE_W'(9)) begin
              data_oe_d = 1'b0;
              state_d   = ST_ACK;
            end else begin
              data_oe_d = ~sh_q[0];
              sh_d      = {1'b0, sh_q[8:1]};
            end
          end
        end
      end
      ST_ACK: begin
        if (frame_tmo) begin
          go_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (clk_fall) begin
            if (!data_filt) begin
              edge_d  = edge_q + EDGE_W'(1);
              state_d = ST_WAIT_IDLE;
            end else begin
              go_error = 1'b1;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (frame_tmo) begin
          go_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (clk_filt && data_filt) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            rx_rst_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Error outputs are set on the transition itself so the lines are
    // released on the very next edge.
    if (go_error) begin
      state_d   = ST_ERROR;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      rx_rst_d  = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      edge_q    <= '0;
      sh_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_rst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      edge_q    <= edge_d;
      sh_q      <= sh_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_rst_q  <= rx_rst_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rx_rst      = rx_rst_q;

endmodule

// File: tb/tb_xps2_tx.sv
// Directed bench for xps2_tx with a PS/2 device model and a result scoreboard.
module tb_xps2_tx;

  localparam int INH    = 50;
  localparam int ST_TMO = 300;
  localparam int FR_TMO = 2000;
  localparam int FLT    = 8;
  localparam int H      = 30;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err, rx_rst;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  xps2_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(ST_TMO),
    .FRAME_TIMEOUT(FR_TMO), .FILTER_LEN(FLT)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .data_in(data_in),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err), .rx_rst(rx_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exp_err;
    logic        check_frame;
    logic [10:0] frame;       // {stop, parity, data[7:0], start}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- device model ----------------
  int          dev_mode   = 0;   // 0 silent, 1 clocks and ACKs, 2 clocks without ACK
  bit          dev_glitch = 1'b0;
  bit          dev_active = 1'b0;
  int          dev_edges  = 0;
  logic [10:0] dev_seq    = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (dev_mode != 0 && !rst && ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) begin
        dev_active = 1'b1;
        dev_edges  = 0;
        dev_seq    = '0;
        repeat (40) @(negedge clk);
        for (int e = 0; e < 11; e++) begin
          repeat (3) @(negedge clk);
          dev_seq[e] = ps2_data_in;
          if (e == 10 && dev_mode == 1) dev_data = 1'b0;
          if (dev_glitch && e == 3) begin
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H - 11) @(negedge clk);
          end else begin
            repeat (H - 3) @(negedge clk);
          end
          dev_clk   = 1'b0;
          dev_edges = e + 1;
          repeat (H) @(negedge clk);
          dev_clk = 1'b1;
        end
        dev_data   = 1'b1;
        dev_active = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    logic err_rise;
    err_rise = err & ~err_prev;
    err_prev = err;
    if (!rst && (done || err_rise)) begin
      check("event_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("outcome_err", 32'(err_rise), 32'(x.exp_err));
        check("outcome_done", 32'(done), 32'(!x.exp_err));
        if (x.check_frame) check("frame_bits", 32'(dev_seq), 32'(x.frame));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic e, input logic cf, input logic [10:0] f);
    exp_t x;
    x.exp_err     = e;
    x.check_frame = cf;
    x.frame       = f;
    exp_q.push_back(x);
  endtask

  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; data_in = b;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || dev_active || busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check({"settle_", name}, 32'(k < 20000), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic count_inhibit(input string name);
    int k = 0;
    int g = 0;
    while (ps2_data_oe == 1'b0 && g < 2000) begin
      if (ps2_clk_oe) k++;
      @(negedge clk);
      g++;
    end
    check({"inhibit_len_", name}, k, INH);
  endtask

  initial begin
    int k, bad;
    repeat (4) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx_rst", rx_rst, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED with ACK: full frame, busy window, done once
    dev_mode = 1;
    push(1'b0, 1'b1, 11'h7DA);
    do_write(8'hED);
    check("busy_after_write", busy, 1);
    check("rx_rst_after_write", rx_rst, 1);
    count_inhibit("ed");
    bad = 0; k = 0;
    while (!done && k < 20000) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
      k++;
    end
    check("busy_held_until_done", bad, 0);
    check("busy_clear_at_done", busy, 0);
    check("rx_rst_clear_at_done", rx_rst, 0);
    wait_quiet("ed");
    check("err_after_ed", err, 0);

    // parity 0 and parity 1 bytes
    push(1'b0, 1'b1, 11'h402);
    do_write(8'h01);
    count_inhibit("01");
    wait_quiet("01");
    push(1'b0, 1'b1, 11'h7FE);
    do_write(8'hFF);
    count_inhibit("ff");
    wait_quiet("ff");

    // device never clocks: start timeout
    dev_mode = 0;
    push(1'b1, 1'b0, 11'h000);
    do_write(8'h12);
    k = 0;
    while (!err && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("start_timeout_cycles", k, INH + 1 + ST_TMO);
    check("tmo_busy", busy, 0);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_data_oe", ps2_data_oe, 0);
    check("tmo_rx_rst", rx_rst, 0);
    wait_quiet("tmo");

    // missing ACK, then a good frame clears err
    dev_mode = 2;
    push(1'b1, 1'b1, 11'h678);
    do_write(8'h3C);
    wait_quiet("noack");
    check("err_sticky_noack", err, 1);
    dev_mode = 1;
    push(1'b0, 1'b1, 11'h5E8);
    do_write(8'hF4);
    check("err_cleared_on_write", err, 0);
    wait_quiet("f4");
    check("err_after_f4", err, 0);

    // write during BITS is ignored
    dev_edges = 0;
    push(1'b0, 1'b1, 11'h754);
    do_write(8'hAA);
    k = 0;
    while (dev_edges < 3 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("reached_edge3", 32'(k < 5000), 1);
    do_write(8'h55);
    check("busy_after_ignored_write", busy, 1);
    wait_quiet("aa");

    // reset at edge 5, then a normal frame
    dev_edges = 0;
    do_write(8'h37);
    k = 0;
    while (dev_edges < 5 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("reached_edge5", 32'(k < 5000), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rx_rst", rx_rst, 0);
    rst = 1'b0;
    wait_quiet("midrst");
    push(1'b0, 1'b1, 11'h402);
    do_write(8'h01);
    wait_quiet("after_rst");

    // 3-cycle clock glitch must not advance the frame
    dev_glitch = 1'b1;
    push(1'b0, 1'b1, 11'h7DA);
    do_write(8'hED);
    wait_quiet("glitch");
    dev_glitch = 1'b0;
    check("err_after_glitch", err, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xps2_tx.md
Name: xps2_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the same PS2_CLK/PS2_DATA lines the PS/2 receiver decodes.
- Memory-mapped on the controller data bus: a write loads a byte, and a status read returns busy/done/error.
- It drives the open-drain lines through active-high output enables; the top level builds the tri-states.
- While a frame is in flight it holds the receiver in reset, so the receiver does not decode the host's own frame.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit duration (100 us at 50 MHz).
- START_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000: maximum cycles from the first falling edge to the ACK (2 ms).
- FILTER_LEN, 8: cycles a synchronised PS/2 line must hold stable before the filtered value changes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sel  in  1  bus select for this block
- we  in  1  bus write enable
- data_in  in  8  command byte to send
- ps2_clk_in  in  1  raw PS2_CLK pad value
- ps2_data_in  in  1  raw PS2_DATA pad value
- ps2_clk_oe  out  1  1 = drive PS2_CLK low
- ps2_data_oe  out  1  1 = drive PS2_DATA low
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes with ACK
- err  out  1  sticky error flag (timeout or missing ACK)
- rx_rst  out  1  hold the PS/2 receiver in reset

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, rx_rst=0, state IDLE, shift register and counters cleared.
- Input conditioning: each raw line goes through a 2-FF synchroniser, then a FILTER_LEN stability filter. A falling edge is filtered clk changing 1->0, detected as a one-cycle strobe.
- Write acceptance: in IDLE, sel&we loads data_in and computes odd parity (p = ~^data_in). It clears err and enters INHIBIT; busy=1 and rx_rst=1 from the next cycle.
- Write while busy is ignored: no reload, no error.
- Line encoding: a transmitted bit b maps to ps2_data_oe=~b.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES. On the final count, set ps2_data_oe=1 (start bit) and go to RELEASE.
- RELEASE: one cycle with ps2_clk_oe=0 and the data line still low. Reset the timeout counter and go to WAIT_START.
- WAIT_START: on the first falling edge, drive bit0 and enter BITS with edge count 1. If START_TIMEOUT expires first, go to ERROR.
- BITS: each falling edge advances one position:
  - edges 2..8 drive bits 1..7 (LSB first);
  - edge 9 drives parity;
  - edge 10 releases data (stop bit = 1, ps2_data_oe=0).
  - The frame counter starts at the first edge. If FRAME_TIMEOUT expires, go to ERROR.
- ACK: on the 11th falling edge, sample filtered data. Low means acknowledged: go to WAIT_IDLE. High goes to ERROR.
- WAIT_IDLE: wait until filtered clk and data are both 1, subject to the frame timeout. Then pulse done for one cycle, clear busy and rx_rst, and return to IDLE.
- ERROR: release both oe outputs immediately, set err=1, clear busy and rx_rst, and return to IDLE. There is no done pulse. err stays set until the next accepted write or reset.
- rst asserted mid-frame: both oe outputs are 0 at the next clock edge and all state returns to reset values; the device times out on its own.
- Output timing: all outputs are registered. Exactly one of done or err is produced per accepted write.
- Counters: one 20-bit timeout counter (≥ log2(START_TIMEOUT)) and one 4-bit edge counter.

Decomposition:
- Shared package (xdefs-style header): PS2_TX_BASE address, status bit positions (bit0 busy, bit1 err), state encoding localparams.
- Sub-module xps2_line_filter (synchroniser + stability filter + falling-edge strobe), instantiated twice. The receiver can later reuse it.

Test Plan:
- Write 0xED against a device model that clocks at 12.5 kHz and ACKs. Required: data line sequence start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Then done pulses once, err=0, and busy is high from the cycle after the write until the done cycle.
- Write 0x01 → parity bit 0. Write 0xFF → parity 1. In both cases ps2_clk_oe is high for exactly INHIBIT_CYCLES cycles before data is pulled low.
- Device never clocks → after INHIBIT_CYCLES+1+START_TIMEOUT cycles: err=1, busy=0, both oe=0, no done pulse.
- Device clocks but leaves data high at edge 11 → err=1, no done. A following write of 0xF4 with correct ACK clears err and produces done.
- Write 0xAA, then write 0x55 during BITS → frame still carries 0xAA and only one done is produced.
- Assert rst at edge 5 → both oe=0, busy=0, rx_rst=0 on the next cycle. A new write afterwards completes normally.
- Inject a 3-cycle glitch on ps2_clk_in with FILTER_LEN=8 → no bit advance.
